bitonic_drain: RTL and testbench
================================

# bitonic_drain

Sequential output stage for the 8-input bitonic sorting network. It captures one sorted 8-element frame from the merge stage in a single cycle with a valid/ready handshake. It then streams the frame out one element per beat on a valid/ready interface with frame-position tags. It is the consumer end of the network's parallel `number_out1..8` bus and converts it to a serial byte stream for downstream logic or the testbench.

## Interface
- `DATA_W`, default 8, element width in bits; it matches the sorter datapath.
- `clk` input 1: the single clock; everything is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: a sorted frame is present on `number_in1..8`.
- `in_ready` output 1: the block accepts a frame this cycle.
- `number_in1` … `number_in8` input DATA_W each: sorted frame, with `number_in1` the largest (descending network order).
- `out_valid` output 1: `out_data` holds a valid element.
- `out_ready` input 1: downstream accepts the element this cycle.
- `out_data` output DATA_W: current element.
- `out_idx` output 3: position of `out_data` within the frame, 0..7.
- `out_last` output 1: high with the 8th element of a frame.
- `busy` output 1: a frame is held; high whenever state is SEND.

## Operation
- FSM states are IDLE and SEND.
- In IDLE:
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid && in_ready`, all 8 inputs are registered into the frame buffer, `idx`←0, and the state moves to SEND.
- In SEND:
  - `out_valid`=1 and `out_data`=buffer[order(idx)].
  - `out_idx`=idx and `out_last`=(idx==7).
- Beat transfer happens only on `out_valid && out_ready`. On a transfer with idx<7, idx increments.
- Last transfer (idx==7 and `out_ready`):
  - `in_ready`=1 in that same cycle, so `in_ready` is combinational on `out_ready`.
  - If `in_valid`=1, the new frame is captured, idx←0, and the state stays SEND. This gives back-to-back frames with no bubble.
  - Otherwise the state moves to IDLE.
- In SEND with idx<7, `in_ready`=0 and `in_valid` is ignored. The upstream source must hold its data.
- When `out_ready`=0, `out_data`, `out_idx` and `out_last` hold stable and idx does not advance.
- Elements are passed through unmodified. There is no arithmetic, and equal values are emitted as-is.

## Timing
- Reset values, in the cycle after `reset` is sampled high:
  - State is IDLE, idx=0 and buffer=0.
  - `out_valid`=0, `out_data`=0, `out_idx`=0, `out_last`=0 and `busy`=0.
  - `in_ready`=0 while `reset` is high, and 1 from the first cycle after deassertion.
- Latency: the first element is valid one cycle after the capture handshake.
- Throughput: 8 beats per frame. Sustained rate is one element per cycle when `out_ready`=1 continuously.
- Reset mid-frame: the frame is discarded and there is no partial `out_last`. `out_valid` drops in the next cycle.
- `out_data`, `out_idx` and `out_last` are registered or decoded from registered state only. `in_ready` is the only combinational output.

## Configuration
- `BITONIC_DRAIN_ASCEND_EN` defined: order(idx)=7−idx. The stream starts with `number_in8`, so output is ascending.
- Not defined: order(idx)=idx. The stream starts with `number_in1`, so output is descending.
- `out_idx` always counts 0..7 regardless of the macro.

## Structure
- Shared package `bitonic_pkg` holds:
  - the state enum (IDLE, SEND);
  - `FRAME_LEN`=8 and `IDX_W`=3;
  - the default `DATA_W`.
- One sub-module, `bitonic_sel8`: a purely combinational 8:1 element selector indexed by the already-ordered index.

## Test plan
- Single frame: reset, then capture 90,80,70,60,50,40,30,20 with `out_ready`=1.
  - `out_data` is 90..20 on 8 consecutive cycles, starting 1 cycle after capture.
  - `out_last` is high only on 20.
  - `in_ready` is 0 during beats 0–6.
- Backpressure: same frame, `out_ready` toggling 1,0,0,1,… .
  - Data, idx and last hold while `out_ready`=0.
  - No element is dropped or duplicated; exactly 8 transfers occur.
- Back-to-back: second frame 8,7,…,1 held valid during the first frame.
  - It is captured on the cycle 20 transfers.
  - 8 follows 20 with no idle cycle, and idx restarts at 0.
- Mid-frame reset: assert reset after the 3rd transfer.
  - Next cycle shows `out_valid`=0 and `busy`=0.
  - `in_ready`=1 after deassertion; a new frame streams from idx 0.
- Ascending build: with `BITONIC_DRAIN_ASCEND_EN`, the frame 90..20 streams as 20,30,…,90.
  - `out_idx` is 0..7 and `out_last` is high with 90.

Source files
------------

// File: rtl/bitonic_pkg.sv
// Shared types and constants for the bitonic sorter output stage.
package bitonic_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int FRAME_LEN  = 8;
  localparam int IDX_W      = 3;
  localparam int DEF_DATA_W = 8;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

endpackage

// File: rtl/bitonic_sel8.sv
// Combinational 8:1 element selector over a flattened frame, element 0 in the LSBs.
module bitonic_sel8
  import bitonic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [FRAME_LEN*DATA_W-1:0] frame,
  input  logic [IDX_W-1:0]            sel,
  output logic [DATA_W-1:0]           data
);

  always_comb begin
    data = '0;
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (sel == IDX_W'(i)) data = frame[i*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/bitonic_drain.sv
// Frame-to-stream drain for the 8-input bitonic sorter.
// Define BITONIC_DRAIN_ASCEND_EN to stream number_in8 first (ascending order).
module bitonic_drain
  import bitonic_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] number_in1,
  input  logic [DATA_W-1:0] number_in2,
  input  logic [DATA_W-1:0] number_in3,
  input  logic [DATA_W-1:0] number_in4,
  input  logic [DATA_W-1:0] number_in5,
  input  logic [DATA_W-1:0] number_in6,
  input  logic [DATA_W-1:0] number_in7,
  input  logic [DATA_W-1:0] number_in8,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_idx,
  output logic              out_last,
  output logic              busy
);

  state_t                      state, state_nxt;
  logic [IDX_W-1:0]            idx, idx_nxt;
  logic [FRAME_LEN*DATA_W-1:0] frame;
  logic                        capture;
  logic                        beat;
  logic                        last_beat;
  logic [IDX_W-1:0]            sel_idx;
  logic [DATA_W-1:0]           sel_data;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    in_ready  = 1'b0;
    beat      = (state == SEND) && out_ready;
    last_beat = beat && (idx == LAST_IDX);

    case (state)
      IDLE:    in_ready = 1'b1;
      SEND:    in_ready = last_beat;
      default: in_ready = 1'b0;
    endcase
    if (reset) in_ready = 1'b0;

    capture = in_valid && in_ready;

    // A capture on the final beat reloads the frame so frames run back-to-back.
    if (capture) begin
      state_nxt = SEND;
      idx_nxt   = '0;
    end else if (last_beat) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else if (beat) begin
      idx_nxt = idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      frame <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (capture) begin
        frame <= {number_in8, number_in7, number_in6, number_in5,
                  number_in4, number_in3, number_in2, number_in1};
      end
    end
  end

`ifdef BITONIC_DRAIN_ASCEND_EN
  assign sel_idx = LAST_IDX - idx;
`else
  assign sel_idx = idx;
`endif

  bitonic_sel8 #(
    .DATA_W (DATA_W)
  ) u_sel (
    .frame (frame),
    .sel   (sel_idx),
    .data  (sel_data)
  );

  // Outputs decode only registered state; out_data reads zero outside SEND.
  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign out_idx   = idx;
  assign out_last  = (state == SEND) && (idx == LAST_IDX);
  assign out_data  = (state == SEND) ? sel_data : '0;

endmodule

// File: tb/tb_bitonic_drain.sv
// Scoreboard bench for bitonic_drain: directed frames, backpressure, back-to-back and mid-frame reset.
module tb_bitonic_drain;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] number_in1, number_in2, number_in3, number_in4;
  logic [7:0] number_in5, number_in6, number_in7, number_in8;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_idx;
  logic       out_last;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];
  logic [7:0]  f_a[8] = '{8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20};
  logic [7:0]  f_b[8] = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
  logic [7:0]  f_c[8] = '{8'd77, 8'd77, 8'd55, 8'd44, 8'd44, 8'd12, 8'd3, 8'd0};
  logic        bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  bitonic_drain #(.DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .number_in1 (number_in1),
    .number_in2 (number_in2),
    .number_in3 (number_in3),
    .number_in4 (number_in4),
    .number_in5 (number_in5),
    .number_in6 (number_in6),
    .number_in7 (number_in7),
    .number_in8 (number_in8),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_el(input logic [7:0] f[8], input int k);
`ifdef BITONIC_DRAIN_ASCEND_EN
    return f[7-k];
`else
    return f[k];
`endif
  endfunction

  task automatic load_frame(input logic [7:0] f[8], input int n_push);
    number_in1 = f[0]; number_in2 = f[1]; number_in3 = f[2]; number_in4 = f[3];
    number_in5 = f[4]; number_in6 = f[5]; number_in7 = f[6]; number_in8 = f[7];
    for (int k = 0; k < n_push; k++)
      exp_q.push_back({exp_el(f, k), 3'(k), (k == 7)});
  endtask

  task automatic drain(input bit use_bp);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      out_ready = use_bp ? bp_pat[c % 4] : 1'b1;
      @(posedge clk); #1;
      c++;
    end
    check("drain_complete", exp_q.size(), 0);
    out_ready = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every transfer and checks holds and in_ready.
  logic        stall_prev = 1'b0;
  logic [11:0] held;
  always @(negedge clk) begin
    logic [11:0] act;
    logic [11:0] e;
    act = {out_data, out_idx, out_last};
    if (!reset && out_valid) begin
      if (stall_prev) check("hold_on_stall", act, held);
      if (out_idx != 3'd7) check("in_ready_mid_frame", in_ready, 0);
      else                 check("in_ready_last_beat", in_ready, out_ready);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got 0x%0h expected none at %0t", act, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat_data_idx_last", act, e);
        end
      end
      stall_prev = !out_ready;
      held       = act;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    load_frame(f_a, 0);

    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready_low", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);

    // Single frame, out_ready held high
    @(posedge clk); #1;
    load_frame(f_a, 8);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("latency_valid", out_valid, 1);
    check("latency_first", out_data, exp_el(f_a, 0));
    drain(1'b0);
    @(negedge clk);
    check("idle_after_frame", out_valid, 0);
    check("busy_after_frame", busy, 0);

    // Backpressure
    @(posedge clk); #1;
    load_frame(f_a, 8);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain(1'b1);
    @(negedge clk);
    check("idle_after_bp", out_valid, 0);

    // Back-to-back frames
    @(posedge clk); #1;
    load_frame(f_a, 8);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    load_frame(f_b, 8);
    c = 0;
    @(negedge clk);
    while (!in_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("b2b_ready_on_last", in_ready, 1);
    check("b2b_last_idx", out_idx, 7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_no_bubble", out_valid, 1);
    check("b2b_idx_restart", out_idx, 0);
    check("b2b_first_data", out_data, exp_el(f_b, 0));
    drain(1'b0);

    // Mid-frame reset after the third transfer
    @(posedge clk); #1;
    load_frame(f_c, 3);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_beats", exp_q.size(), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_last", out_last, 0);
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready_after", in_ready, 1);
    @(posedge clk); #1;
    load_frame(f_c, 8);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_idx0", out_idx, 0);
    drain(1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
